// File: rtl/player_count_if.sv
// Button-stage to display-stage bundle for the player counter: raw button levels in,
// count/BCD digits/strobes/limit flags out.
interface player_count_if #(
    parameter int unsigned CNT_W = 7
);
    logic             up;
    logic             down;
    logic [CNT_W-1:0] count;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic             inc_pulse;
    logic             dec_pulse;
    logic             at_min;
    logic             at_max;

    modport master (
        output up, down,
        input  count, tens, ones, inc_pulse, dec_pulse, at_min, at_max
    );

    modport slave (
        input  up, down,
        output count, tens, ones, inc_pulse, dec_pulse, at_min, at_max
    );
endinterface

// File: rtl/player_count.sv
// Saturating player counter: synchronizes and debounces up/down buttons, turns each clean press
// into one step, and keeps binary plus incremental BCD copies of the count.
module player_count #(
    parameter int unsigned MAX_COUNT       = 99,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 7
) (
    input logic           clk,
    input logic           reset,
    player_count_if.slave pc
);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      db_q, db_d;
    logic [1:0]      db_prev_q, db_prev_d;
    logic [1:0]      pulse_q, pulse_d;
    logic [DB_W-1:0] stab_q [2];
    logic [DB_W-1:0] stab_d [2];

    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;

    always_comb begin
        sync1_d   = {pc.down, pc.up};
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        pulse_d   = db_q & ~db_prev_q;
        for (int b = 0; b < 2; b++) begin
            stab_d[b] = '0;
            if (sync2_q[b] != db_q[b]) begin
                // Accept the new level on the last of DEBOUNCE_CYCLES consecutive mismatches.
                if (stab_q[b] == DB_LAST) begin
                    db_d[b] = sync2_q[b];
                end else begin
                    stab_d[b] = stab_q[b] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        case (pulse_q)
            2'b01: begin
                if (count_q < CNT_MAX) begin
                    count_d = count_q + 1'b1;
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
            end
            2'b10: begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
            default: ;  // no pulse, or both at once: hold
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            pulse_q   <= '0;
            stab_q[0] <= '0;
            stab_q[1] <= '0;
            count_q   <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            pulse_q   <= pulse_d;
            stab_q[0] <= stab_d[0];
            stab_q[1] <= stab_d[1];
            count_q   <= count_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
        end
    end

    assign pc.count     = count_q;
    assign pc.tens      = tens_q;
    assign pc.ones      = ones_q;
    assign pc.inc_pulse = pulse_q[0];
    assign pc.dec_pulse = pulse_q[1];
    assign pc.at_min    = (count_q == '0);
    assign pc.at_max    = (count_q == CNT_MAX);
endmodule

// File: tb/tb_player_count.sv
// Self-checking bench for player_count: directed scenarios plus random button activity, all
// outputs compared every cycle against a behavioural model of the press/debounce/count rules.
module tb_player_count;
    localparam int unsigned MAXC = 12;
    localparam int unsigned DBC  = 4;
    localparam int unsigned CW   = 7;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    player_count_if #(.CNT_W(CW)) pc ();

    player_count #(
        .MAX_COUNT      (MAXC),
        .DEBOUNCE_CYCLES(DBC),
        .CNT_W          (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pc   (pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: two-stage sampling delay, debounced level, mismatch run length per button.
    int m_d1[2], m_d2[2], m_db[2], m_run[2], m_rose[2];
    int m_inc, m_dec, m_count;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_d1[b] = 0; m_d2[b] = 0; m_db[b] = 0; m_run[b] = 0; m_rose[b] = 0;
        end
        m_inc = 0; m_dec = 0; m_count = 0;
    endtask

    task automatic model_step();
        int raw[2];
        int s;
        raw[0] = int'(pc.up);
        raw[1] = int'(pc.down);
        if (reset) begin
            model_reset();
            return;
        end
        if (m_inc == 1 && m_dec == 0 && m_count < int'(MAXC)) m_count++;
        else if (m_dec == 1 && m_inc == 0 && m_count > 0) m_count--;
        m_inc = m_rose[0];
        m_dec = m_rose[1];
        for (int b = 0; b < 2; b++) begin
            s       = m_d2[b];
            m_d2[b] = m_d1[b];
            m_d1[b] = raw[b];
            m_rose[b] = 0;
            if (s != m_db[b]) begin
                m_run[b]++;
                if (m_run[b] == int'(DBC)) begin
                    m_db[b]   = s;
                    m_run[b]  = 0;
                    m_rose[b] = s;
                end
            end else begin
                m_run[b] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("count", int'(pc.count), m_count);
        check_eq("tens", int'(pc.tens), m_count / 10);
        check_eq("ones", int'(pc.ones), m_count % 10);
        check_eq("inc_pulse", int'(pc.inc_pulse), m_inc);
        check_eq("dec_pulse", int'(pc.dec_pulse), m_dec);
        check_eq("at_min", int'(pc.at_min), int'(m_count == 0));
        check_eq("at_max", int'(pc.at_max), int'(m_count == int'(MAXC)));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        ticks(n);
        reset = 1'b0;
    endtask

    task automatic press(input int b, input int hi, input int lo);
        if (b == 0) pc.up = 1'b1; else pc.down = 1'b1;
        ticks(hi);
        if (b == 0) pc.up = 1'b0; else pc.down = 1'b0;
        ticks(lo);
    endtask

    initial begin
        int first, pulses, both, c0, e;
        pc.up   = 1'b0;
        pc.down = 1'b0;
        model_reset();

        // Reset then idle
        do_reset(2);
        check_eq("rst_count", int'(pc.count), 0);
        check_eq("rst_at_min", int'(pc.at_min), 1);
        check_eq("rst_at_max", int'(pc.at_max), 0);
        ticks(50);

        // Clean press: count changes at E0+7, i.e. after tick index 8
        pc.up = 1'b1;
        first = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (pc.inc_pulse) pulses++;
            if (first == 0 && pc.count == CW'(1)) first = i;
        end
        check_eq("press_latency", first, int'(DBC) + 4);
        check_eq("press_pulses", pulses, 1);
        pc.up = 1'b0;
        ticks(20);
        check_eq("press_release", int'(pc.count), 1);

        // Bounce then stable high: one step
        c0 = int'(pc.count);
        for (int i = 0; i < 8; i++) begin
            pc.up = ~pc.up;
            ticks(2);
        end
        pc.up = 1'b1;
        ticks(20);
        pc.up = 1'b0;
        ticks(20);
        check_eq("bounce_step", int'(pc.count), c0 + 1);
        press(0, 3, 20);
        check_eq("glitch_ignored", int'(pc.count), c0 + 1);

        // Saturation and BCD walk up, then down to zero
        do_reset(2);
        for (int i = 0; i < 14; i++) begin
            press(0, 10, 10);
            e = (i + 1 > int'(MAXC)) ? int'(MAXC) : i + 1;
            check_eq("sat_up_tens", int'(pc.tens), e / 10);
            check_eq("sat_up_ones", int'(pc.ones), e % 10);
        end
        check_eq("sat_count", int'(pc.count), int'(MAXC));
        check_eq("sat_at_max", int'(pc.at_max), 1);
        for (int i = 0; i < 13; i++) begin
            press(1, 10, 10);
            e = (int'(MAXC) - i - 1 < 0) ? 0 : int'(MAXC) - i - 1;
            check_eq("sat_dn_count", int'(pc.count), e);
            check_eq("sat_dn_ones", int'(pc.ones), e % 10);
        end
        check_eq("floor_at_min", int'(pc.at_min), 1);

        // Simultaneous presses hold the count
        do_reset(1);
        for (int i = 0; i < 5; i++) press(0, 10, 10);
        pc.up = 1'b1; pc.down = 1'b1;
        both = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pc.inc_pulse && pc.dec_pulse) both++;
        end
        pc.up = 1'b0; pc.down = 1'b0;
        ticks(20);
        check_eq("simul_both", both, 1);
        check_eq("simul_count", int'(pc.count), 5);

        // Reset in the middle of a held press
        do_reset(1);
        for (int i = 0; i < 7; i++) press(0, 10, 10);
        check_eq("mid_pre", int'(pc.count), 7);
        pc.up = 1'b1;
        ticks(2);
        do_reset(1);
        check_eq("mid_reset", int'(pc.count), 0);
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (first == 0 && pc.count == CW'(1)) first = i;
        end
        check_eq("mid_latency", first, int'(DBC) + 4);
        pc.up = 1'b0;
        ticks(20);
        check_eq("mid_final", int'(pc.count), 1);

        // Random button activity with occasional reset
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) pc.up = ~pc.up;
            if ($urandom_range(0, 8) == 0) pc.down = ~pc.down;
            reset = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/player_count.md
# player_count

Downstream of the button-input stage. Takes that stage's raw `up`/`down` levels and its `reset` level. Debounces each button and converts each clean press into a single step of a saturating player count. Drives the count in binary and as two BCD digits for the display stage.

## Interface
Parameters:
- `MAX_COUNT`, 99: upper saturation limit of the count; legal range 1..99.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before a button level is accepted (5 ms at 100 MHz); minimum 2.
- `CNT_W`, 7: width of `count`; must hold `MAX_COUNT`.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  reset, synchronous, active-high; driven by the button-input stage's game-reset output.
- `up`  input  1  raw player-count-up level; asynchronous to `clk`, may bounce.
- `down`  input  1  raw player-count-down level; asynchronous to `clk`, may bounce.
- `count`  output  CNT_W  current player count, binary.
- `tens`  output  4  BCD tens digit of `count`.
- `ones`  output  4  BCD ones digit of `count`.
- `inc_pulse`  output  1  one-cycle strobe per accepted `up` press.
- `dec_pulse`  output  1  one-cycle strobe per accepted `down` press.
- `at_min`  output  1  high when `count == 0`.
- `at_max`  output  1  high when `count == MAX_COUNT`.

## Operation
- Per button, a 2-flop synchronizer feeds a debouncer.
  - The debouncer holds a debounced level `db` and a stability counter of width clog2(DEBOUNCE_CYCLES).
  - Counter clears whenever the synchronized level equals `db`.
  - Otherwise it increments.
  - When the mismatch has persisted DEBOUNCE_CYCLES consecutive cycles, `db` takes the synchronized level and the counter clears.
- Rising edge of `db` registers a one-cycle `inc_pulse` (up) or `dec_pulse` (down). Falling edges produce nothing.
- Holding a button produces exactly one pulse; there is no auto-repeat.
- Count update, on the edge after a pulse:
  - `inc_pulse` alone: count+1 if count < MAX_COUNT, else hold.
  - `dec_pulse` alone: count-1 if count > 0, else hold.
  - Both in the same cycle: hold. Neither step is applied.
- `tens`/`ones` are kept as an incremental BCD pair updated on the same edge as `count`, never one cycle behind.
  - Increment: ones 9 -> 0 with tens+1.
  - Decrement: ones 0 -> 9 with tens-1.
- `at_min`/`at_max` are combinational from `count`.
- `reset` high at an edge sets the following, overriding any pulse in that cycle:
  - count = 0, tens = 0, ones = 0
  - both `db` = 0, both stability counters = 0, synchronizer flops = 0
  - inc_pulse = 0, dec_pulse = 0
  - Hence at_min = 1, at_max = 0.
- A button held through reset release is re-debounced from `db` = 0. It yields exactly one step DEBOUNCE_CYCLES+3 edges after the first post-reset edge that samples it high.

## Timing
- Edge E0 is the first edge sampling `up` high, with `up` held stable thereafter.
- sync2 is high after E1.
- `db` rises at E1+DEBOUNCE_CYCLES.
- `inc_pulse` is high for exactly the cycle after E2+DEBOUNCE_CYCLES.
- `count`/`tens`/`ones` change at E3+DEBOUNCE_CYCLES. Total press-to-count latency is DEBOUNCE_CYCLES+3 edges.
- Release latency is the same (DEBOUNCE_CYCLES+1 edges to `db` fall) and causes no output change.
- A glitch or bounce interval shorter than DEBOUNCE_CYCLES consecutive cycles never changes `db`.
- Minimum press-to-press spacing is 2×DEBOUNCE_CYCLES+2 cycles; each such press counts once.
- The `up` and `down` paths are fully independent; there is no arbitration beyond the simultaneous-pulse hold rule.

## Test plan
Benches run with DEBOUNCE_CYCLES=4 and MAX_COUNT=12.
- Reset then idle: assert `reset` 2 cycles -> count=0, tens=0, ones=0, at_min=1, at_max=0, no pulses for 50 cycles.
- Clean press: `up` high 20 cycles from E0 -> `inc_pulse` high one cycle only, count 0->1 at edge E0+7, no further change while held or on release.
- Bounce: `up` toggling every 2 cycles for 16 cycles then stable high -> exactly one increment.
  - Separate case: a 3-cycle `up` glitch -> no increment.
- Saturation and BCD: 14 clean `up` presses -> count walks 0..12 with tens/ones 0/9 -> 1/0 at 9->10. Count holds at 12, at_max=1.
  - Then 13 `down` presses -> reaches 0 and holds, at_min=1, ones 0 -> 9 at 10->9.
- Simultaneous: with count=5, `up` and `down` rise on the same edge, each held 20 cycles -> both pulses in the same cycle, count stays 5.
- Reset mid-operation: count=7, `up` held; assert `reset` 1 cycle mid-debounce -> count=0 next edge, then exactly one increment to 1 at DEBOUNCE_CYCLES+3 edges after reset release.
